mem_stage: RTL and testbench

// Memory stage: consumer end of the executed req/ack handshake driven by the execute stage.

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_stage_if.sv | 65 ++++++
 rtl/mem_lsu_align.sv | 62 ++++++
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Memory stage shared definitions: funct3 access codes, FSM states and
// the capture bundle held while an instruction is in flight.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_ACC  = 2'd1,
        MEM_REQ  = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [63:0] addr;
        logic        store;
    } cap_t;

    function automatic logic is_mem_op(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Handshake bundles around the memory stage: execute->mem, data memory,
// and mem->writeback.
interface ex_mem_if;
    logic        executed_req;
    logic        executed_ack;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [63:0] rd_wdata;
    logic [63:0] sdata;
    logic        memren;
    logic        memwen;

    modport master (
        output executed_req, pc, inst, funct3, rd, rd_wen,
        output rd_wdata, sdata, memren, memwen,
        input  executed_ack
    );
    modport slave (
        input  executed_req, pc, inst, funct3, rd, rd_wen,
        input  rd_wdata, sdata, memren, memwen,
        output executed_ack
    );
endinterface

interface dmem_if;
    logic        req;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        ack;
    logic [63:0] rdata;

    modport master (
        output req, wen, addr, wdata, wmask,
        input  ack, rdata
    );
    modport slave (
        input  req, wen, addr, wdata, wmask,
        output ack, rdata
    );
endinterface

interface mem_wb_if;
    logic        memoryed_req;
    logic        memoryed_ack;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [63:0] rd_wdata;
    logic        err;

    modport master (
        output memoryed_req, pc, inst, rd, rd_wen, rd_wdata, err,
        input  memoryed_ack
    );
    modport slave (
        input  memoryed_req, pc, inst, rd, rd_wen, rd_wdata, err,
        output memoryed_ack
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Load/store lane alignment: misalign check, store strobes and data shift,
// load shift with sign or zero extension.
module mem_lsu_align (
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] sdata,
    input  logic [63:0] rdata,
    output logic        misalign,
    output logic [7:0]  wmask,
    output logic [63:0] wdata,
    output logic [63:0] ldata
);

    logic [2:0]  off;
    logic [5:0]  sh;
    logic [63:0] rsh;
    logic        sext;
    logic        sz_b;
    logic        sz_h;
    logic        sz_w;
    logic        sz_d;

    assign off   = addr[2:0];
    assign sh    = {off, 3'b000};
    assign sext  = ~funct3[2];
    assign sz_b  = funct3[1:0] == 2'b00;
    assign sz_h  = funct3[1:0] == 2'b01;
    assign sz_w  = funct3[1:0] == 2'b10;
    assign sz_d  = funct3[1:0] == 2'b11;
    assign wdata = sdata << sh;
    assign rsh   = rdata >> sh;

    // funct3[1:0]==11 covers both the doubleword and the undefined 111 code
    always_comb begin
        misalign = 1'b0;
        wmask    = 8'h00;
        ldata    = rsh;
        unique case (1'b1)
            sz_b: begin
                wmask = 8'h01 << off;
                ldata = {{56{sext & rsh[7]}}, rsh[7:0]};
            end
            sz_h: begin
                misalign = off[0];
                wmask    = 8'h03 << off;
                ldata    = {{48{sext & rsh[15]}}, rsh[15:0]};
            end
            sz_w: begin
                misalign = |off[1:0];
                wmask    = 8'h0F << off;
                ldata    = {{32{sext & rsh[31]}}, rsh[31:0]};
            end
            sz_d: begin
                misalign = |off;
                wmask    = 8'hFF;
                ldata    = rsh;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: captures one executed instruction, performs at most one
// data-memory access, and hands the result to writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic     clk,
    input  logic     rst_n,
    ex_mem_if.slave  ex,
    dmem_if.master   dmem,
    mem_wb_if.master wb
);

    localparam int unsigned TMAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam int unsigned CW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    mem_state_e state_q;
    mem_state_e state_d;
    cap_t       cap_q;

    logic          ack_q;
    logic          dreq_q;
    logic          dwen_q;
    logic [63:0]   daddr_q;
    logic [63:0]   dwdata_q;
    logic [7:0]    dwmask_q;
    logic [63:0]   res_q;
    logic          res_wen_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic        idle;
    logic        take;
    logic        mem_op;
    logic        tmo;
    logic        wb_valid;
    logic [2:0]  a_f3;
    logic [63:0] a_addr;
    logic        mis;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] ldata;

    assign idle   = state_q == MEM_IDLE;
    assign take   = idle & ex.executed_req;
    assign mem_op = is_mem_op(ex.memren, ex.memwen);
    assign tmo    = (TIMEOUT != 0) && (cnt_q == CW'(TMAX));

    // Align on live inputs while idle, on the captured op afterwards
    assign a_f3   = idle ? ex.funct3 : cap_q.funct3;
    assign a_addr = idle ? ex.rd_wdata : cap_q.addr;

    mem_lsu_align u_align (
        .funct3   (a_f3),
        .addr     (a_addr),
        .sdata    (ex.sdata),
        .rdata    (dmem.rdata),
        .misalign (mis),
        .wmask    (wmask),
        .wdata    (wdata),
        .ldata    (ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wb_valid = 1'b0;
        unique case (state_q)
            MEM_IDLE: begin
                if (ex.executed_req) begin
                    state_d = (mem_op & ~mis) ? MEM_REQ : MEM_DONE;
                end
            end
            MEM_REQ: begin
                if (dmem.ack | tmo) begin
                    state_d = MEM_DONE;
                end
            end
            MEM_DONE: begin
                wb_valid = 1'b1;
                if (wb.memoryed_ack) begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_ACC:  state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q     <= '0;
            ack_q     <= 1'b0;
            dreq_q    <= 1'b0;
            dwen_q    <= 1'b0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            dwmask_q  <= '0;
            res_q     <= '0;
            res_wen_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ack_q <= take;
            if (take) begin
                cap_q <= '{
                    pc:     ex.pc,
                    inst:   ex.inst,
                    funct3: ex.funct3,
                    rd:     ex.rd,
                    rd_wen: ex.rd_wen,
                    addr:   ex.rd_wdata,
                    store:  ex.memwen
                };
                res_q     <= ex.rd_wdata;
                res_wen_q <= ex.rd_wen & ~mem_op;
                err_q     <= mem_op & mis;
                dreq_q    <= mem_op & ~mis;
                cnt_q     <= '0;
                if (mem_op & ~mis) begin
                    dwen_q   <= ex.memwen;
                    daddr_q  <= {ex.rd_wdata[63:3], 3'b000};
                    dwdata_q <= wdata;
                    dwmask_q <= ex.memwen ? wmask : 8'h00;
                end
            end else if (state_q == MEM_REQ) begin
                if (dmem.ack) begin
                    dreq_q <= 1'b0;
                    if (!cap_q.store) begin
                        res_q     <= ldata;
                        res_wen_q <= cap_q.rd_wen;
                    end
                end else if (tmo) begin
                    dreq_q <= 1'b0;
                    err_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign ex.executed_ack = ack_q;

    assign dmem.req   = dreq_q;
    assign dmem.wen   = dwen_q;
    assign dmem.addr  = daddr_q;
    assign dmem.wdata = dwdata_q;
    assign dmem.wmask = dwmask_q;

    assign wb.memoryed_req = wb_valid;
    assign wb.pc           = cap_q.pc;
    assign wb.inst         = cap_q.inst;
    assign wb.rd           = cap_q.rd;
    assign wb.rd_wen       = res_wen_q;
    assign wb.rd_wdata     = res_q;
    assign wb.err          = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random traffic, scoreboarded against a
// byte-addressed memory model and per-instruction expected results.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_mem_if ex ();
    dmem_if   dm ();
    mem_wb_if wb ();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (ex),
        .dmem  (dm),
        .wb    (wb)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] data;
        logic        err;
        bit          chk_data;
    } wb_exp_t;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } dm_exp_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] a;
        logic [63:0] sd;
        logic        ren;
        logic        wr;
    } ins_t;

    wb_exp_t wq[$];
    dm_exp_t dq[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_acks = 0;
    int n_issued = 0;
    int wb_delay_fixed = -1;
    bit dm_hold = 0;
    bit chk_tlen = 0;

    logic [7:0]  mb [longint unsigned];
    logic [63:0] rm [longint unsigned];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ib(input longint unsigned a);
        return 8'(a * 37 + 17) ^ 8'(a >> 8);
    endfunction

    function automatic logic [7:0] mrd(input longint unsigned a);
        return mb.exists(a) ? mb[a] : ib(a);
    endfunction

    function automatic logic [63:0] rrd(input longint unsigned a);
        logic [63:0] v;
        if (rm.exists(a)) return rm[a];
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ib(a + longint'(i));
        return v;
    endfunction

    // Expected result from the access rules, with byte-level memory
    function automatic void predict(input ins_t t, output wb_exp_t e,
                                    output bit has_dm, output dm_exp_t d);
        int sz;
        int off;
        logic [63:0] v;
        sz = 1 << t.f3[1:0];
        off = int'(t.a[2:0]);
        e.pc = t.pc; e.inst = t.inst; e.rd = t.rd; e.err = 1'b0;
        e.chk_data = 1; e.wen = t.wen; e.data = t.a;
        has_dm = 0;
        d = '{default: 0};
        if (!(t.ren || t.wr)) return;
        if ((t.a % 64'(sz)) != 0) begin
            e.err = 1'b1; e.wen = 1'b0; e.chk_data = 0;
            return;
        end
        has_dm = 1;
        d.addr = t.a & ~64'h7;
        d.wen = t.wr;
        if (t.wr) begin
            e.wen = 1'b0; e.chk_data = 0;
            d.wmask = 8'(((1 << sz) - 1) << off);
            d.wdata = t.sd << (8 * off);
            for (int i = 0; i < sz; i++) mb[t.a + 64'(i)] = t.sd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = mrd(t.a + 64'(i));
            if (sz < 8 && !t.f3[2] && v[8*sz-1])
                for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
            e.data = v;
        end
    endfunction

    function automatic ins_t mk(input logic [2:0] f3, input logic [4:0] rd,
                                input logic wen, input logic [63:0] a,
                                input logic [63:0] sd, input logic ren,
                                input logic wr);
        ins_t t;
        t.pc = {$urandom, $urandom}; t.inst = $urandom;
        t.f3 = f3; t.rd = rd; t.wen = wen; t.a = a; t.sd = sd;
        t.ren = ren; t.wr = wr;
        return t;
    endfunction

    task automatic push(input ins_t t);
        wb_exp_t e;
        dm_exp_t d;
        bit h;
        predict(t, e, h, d);
        wq.push_back(e);
        if (h) dq.push_back(d);
    endtask

    task automatic drive(input ins_t t, input int hold, output int lat);
        int n = 0;
        @(negedge clk);
        ex.pc = t.pc; ex.inst = t.inst; ex.funct3 = t.f3; ex.rd = t.rd;
        ex.rd_wen = t.wen; ex.rd_wdata = t.a; ex.sdata = t.sd;
        ex.memren = t.ren; ex.memwen = t.wr; ex.executed_req = 1'b1;
        n_issued++;
        do begin
            @(negedge clk);
            n++;
        end while (!ex.executed_ack && n < 100);
        if (!ex.executed_ack) begin
            n_cmp++; n_err++;
            $display("FAIL capture_timeout: got no ack want ack");
        end
        for (int i = 1; i < hold; i++) @(negedge clk);
        ex.executed_req = 1'b0;
        lat = n;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((wq.size() != 0 || dq.size() != 0 || wb.memoryed_req ||
                dm.req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL idle_wait: got %0d pending want 0", wq.size());
        end
    endtask

    always @(negedge clk) if (ex.executed_ack) n_acks++;

    // Writeback monitor: random accept delay, pops and compares on handshake
    initial begin
        int w;
        int dl;
        logic [63:0] snap;
        wb_exp_t e;
        w = 0; dl = 0; snap = '0;
        wb.memoryed_ack = 1'b0;
        forever begin
            @(negedge clk);
            wb.memoryed_ack = 1'b0;
            if (rst_n && wb.memoryed_req) begin
                if (w == 0) begin
                    dl = (wb_delay_fixed >= 0) ? wb_delay_fixed
                                               : int'($urandom_range(0, 2));
                    snap = wb.rd_wdata;
                end
                if (w >= dl) begin
                    wb.memoryed_ack = 1'b1;
                    w = 0;
                    chk("wb_hold", wb.rd_wdata, snap);
                    if (wq.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL wb_unexpected: got pc %h want none",
                                 wb.pc);
                    end else begin
                        e = wq.pop_front();
                        chk("wb_pc", wb.pc, e.pc);
                        chk("wb_inst", 64'(wb.inst), 64'(e.inst));
                        chk("wb_rd", 64'(wb.rd), 64'(e.rd));
                        chk("wb_rd_wen", 64'(wb.rd_wen), 64'(e.wen));
                        chk("wb_err", 64'(wb.err), 64'(e.err));
                        if (e.chk_data) chk("wb_data", wb.rd_wdata, e.data);
                    end
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    // Data-memory responder with its own doubleword store
    initial begin
        dm_exp_t d;
        int n;
        logic [63:0] a;
        logic [63:0] v;
        dm.ack = 1'b0;
        dm.rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && dm.req) begin
                a = dm.addr;
                if (dq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL dmem_unexpected: got addr %h want none", a);
                end else begin
                    d = dq.pop_front();
                    chk("dmem_addr", a, d.addr);
                    chk("dmem_wen", 64'(dm.wen), 64'(d.wen));
                    if (d.wen) begin
                        chk("dmem_wdata", dm.wdata, d.wdata);
                        chk("dmem_wmask", 64'(dm.wmask), 64'(d.wmask));
                    end
                end
                if (dm_hold) begin
                    n = 1;
                    while (dm.req && n < 50) begin
                        @(negedge clk);
                        if (dm.req) n++;
                    end
                    if (chk_tlen) chk("timeout_len", 64'(n), 64'(TO));
                    repeat (3) @(negedge clk);
                    dm.rdata = {$urandom, $urandom};
                    dm.ack = 1'b1;
                    @(negedge clk);
                    dm.ack = 1'b0;
                end else begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    chk("dmem_req_held", 64'(dm.req), 64'd1);
                    v = rrd(a);
                    dm.rdata = v;
                    dm.ack = 1'b1;
                    if (dm.wen) begin
                        for (int i = 0; i < 8; i++)
                            if (dm.wmask[i]) v[8*i +: 8] = dm.wdata[8*i +: 8];
                        rm[a] = v;
                    end
                    @(negedge clk);
                    dm.ack = 1'b0;
                    chk("dmem_req_drop", 64'(dm.req), 64'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t t;
        int lat;
        int a0;
        ex.executed_req = 1'b0; ex.pc = '0; ex.inst = '0; ex.funct3 = '0;
        ex.rd = '0; ex.rd_wen = 1'b0; ex.rd_wdata = '0; ex.sdata = '0;
        ex.memren = 1'b0; ex.memwen = 1'b0;
        #2;
        chk("rst_exec_ack", 64'(ex.executed_ack), 64'd0);
        chk("rst_dmem_req", 64'(dm.req), 64'd0);
        chk("rst_wb_req", 64'(wb.memoryed_req), 64'd0);
        chk("rst_wb_data", wb.rd_wdata, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-memory pass-through, one-cycle latency
        t = mk(F3_D, 5'd5, 1'b1, 64'h1234, 64'd0, 1'b0, 1'b0);
        push(t);
        drive(t, 1, lat);
        chk("nm_capture_lat", 64'(lat), 64'd1);
        chk("nm_wb_req_c1", 64'(wb.memoryed_req), 64'd1);
        @(negedge clk);
        chk("nm_ack_oneshot", 64'(ex.executed_ack), 64'd0);
        wait_idle();

        // Store doubleword, then LB / LBU of the sign byte
        t = mk(F3_D, 5'd1, 1'b1, 64'h1000, 64'h0000_0000_8000_0000, 1'b0, 1'b1);
        push(t);
        drive(t, 1, lat);
        wait_idle();
        t = mk(F3_B, 5'd2, 1'b1, 64'h1003, 64'd0, 1'b1, 1'b0);
        push(t);
        wq[wq.size()-1].data = 64'hFFFF_FFFF_FFFF_FF80;
        drive(t, 1, lat);
        wait_idle();
        t = mk(F3_BU, 5'd3, 1'b1, 64'h1003, 64'd0, 1'b1, 1'b0);
        push(t);
        wq[wq.size()-1].data = 64'h80;
        drive(t, 1, lat);
        wait_idle();

        // SH to the top lane; memren+memwen counts as a store
        t = mk(F3_H, 5'd4, 1'b1, 64'h1006, 64'hBEEF, 1'b1, 1'b1);
        push(t);
        dq[dq.size()-1].wmask = 8'hC0;
        dq[dq.size()-1].wdata = 64'hBEEF_0000_0000_0000;
        drive(t, 1, lat);
        wait_idle();
        t = mk(F3_HU, 5'd6, 1'b1, 64'h1006, 64'd0, 1'b1, 1'b0);
        push(t);
        wq[wq.size()-1].data = 64'hBEEF;
        drive(t, 1, lat);
        wait_idle();

        // Misaligned LW: no dmem access, result next cycle
        t = mk(F3_W, 5'd7, 1'b1, 64'h1002, 64'd0, 1'b1, 1'b0);
        push(t);
        drive(t, 1, lat);
        chk("mis_wb_req_c1", 64'(wb.memoryed_req), 64'd1);
        chk("mis_no_dmem", 64'(dm.req), 64'd0);
        wait_idle();

        // Withheld dmem ack: timeout after TO cycles, late ack ignored
        dm_hold = 1; chk_tlen = 1;
        t = mk(F3_D, 5'd8, 1'b1, 64'h1010, 64'd0, 1'b1, 1'b0);
        push(t);
        wq[wq.size()-1].err = 1'b1;
        wq[wq.size()-1].wen = 1'b0;
        wq[wq.size()-1].chk_data = 0;
        drive(t, 1, lat);
        wait_idle();
        repeat (8) @(negedge clk);
        chk("late_ack_wb", 64'(wb.memoryed_req), 64'd0);
        chk("late_ack_dmem", 64'(dm.req), 64'd0);
        dm_hold = 0; chk_tlen = 0;

        // Executed req held 3 cycles with slow writeback: one capture only
        wb_delay_fixed = 5;
        a0 = n_acks;
        t = mk(F3_D, 5'd9, 1'b1, 64'h5555, 64'd0, 1'b0, 1'b0);
        push(t);
        drive(t, 3, lat);
        wait_idle();
        repeat (4) @(negedge clk);
        chk("held_req_acks", 64'(n_acks - a0), 64'd1);
        wb_delay_fixed = -1;

        // Reset in the middle of a dmem request
        dm_hold = 1;
        t = mk(F3_D, 5'd10, 1'b1, 64'h1018, 64'd0, 1'b1, 1'b0);
        push(t);
        drive(t, 1, lat);
        chk("req_before_rst", 64'(dm.req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dmem_req", 64'(dm.req), 64'd0);
        chk("rst_mid_dmem_addr", dm.addr, 64'd0);
        chk("rst_mid_wb_req", 64'(wb.memoryed_req), 64'd0);
        chk("rst_mid_wb_pc", wb.pc, 64'd0);
        chk("rst_mid_err", 64'(wb.err), 64'd0);
        wq.delete();
        dq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", 64'(wb.memoryed_req), 64'd0);
        dm_hold = 0;

        // Random back-to-back traffic
        for (int k = 0; k < 150; k++) begin
            int kind;
            int sz;
            int off;
            logic [2:0] f3;
            logic ren;
            logic wr;
            kind = int'($urandom_range(0, 3));
            ren = (kind == 1) || (kind == 3);
            wr = kind >= 2;
            f3 = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            sz = 1 << f3[1:0];
            off = int'($urandom_range(0, 31));
            if ($urandom_range(0, 5) != 0) off = off & ~(sz - 1);
            t = mk(f3, 5'($urandom), 1'($urandom),
                   (ren || wr) ? 64'h1000 + 64'(off) : {$urandom, $urandom},
                   {$urandom, $urandom}, ren, wr);
            push(t);
            drive(t, 1, lat);
        end
        wait_idle();
        repeat (5) @(negedge clk);
        chk("ack_count", 64'(n_acks), 64'(n_issued));
        chk("wb_left", 64'(wq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
